// File: rtl/camera_bayer_rgb565.sv
// camera_bayer_rgb565
// Converts a raw D5M Bayer stream (even rows: G1 R G1 R ..., odd rows:
// B G2 B G2 ...) into half-resolution RGB565 by 2x2 binning. Each even-row
// pair is parked in a single line buffer as {G1, R[top 5 bits]}. Each
// odd-row pair is combined with its buffered partner, one clock after the
// pair completes.
//
// Optional feature macro: BAYER_FRAME_CNT_EN (adds frame_pixel_count).
//
// Ports:
//   clk                pixel clock, all logic on the rising edge
//   reset_n            synchronous active-low reset
//   in_frame_valid     camera FVAL
//   in_line_valid      camera LVAL
//   in_data            raw Bayer pixel, qualified by FVAL & LVAL
//   out_valid          one-cycle strobe for out_pixel
//   out_pixel          RGB565 {R[4:0], G[5:0], B[4:0]}
//   out_sof            high with the first output of a frame
//   out_eol            high with the last output of an output line
//   overflow           sticky: a line exceeded LINE_WIDTH; cleared on FVAL rise
//   frame_pixel_count  (BAYER_FRAME_CNT_EN only) outputs in the last frame
module camera_bayer_rgb565 #(
    parameter int LINE_WIDTH = 640,
    parameter int DATA_W     = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_frame_valid,
    input  logic              in_line_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [15:0]       out_pixel,
    output logic              out_sof,
    output logic              out_eol,
    output logic              overflow
`ifdef BAYER_FRAME_CNT_EN
    ,
    output logic [31:0]       frame_pixel_count
`endif
);

    localparam int DEPTH = LINE_WIDTH / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(LINE_WIDTH + 1);
    localparam int BW    = DATA_W + 5;
    localparam logic [CW-1:0] COL_MAX  = CW'(LINE_WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);

    logic              fval_q, fval_d;
    logic              lval_q, lval_d;
    logic [CW-1:0]     col_q, col_d;
    logic              row_odd_q, row_odd_d;
    logic              first_pending_q, first_pending_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] g1_q, g1_d;
    logic [4:0]        b_q, b_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_pixel_q, out_pixel_d;
    logic              out_sof_q, out_sof_d;
    logic              out_last_col_q, out_last_col_d;

    // Line buffer entry: {G1 full width, R top 5 bits}
    logic [BW-1:0]     line_buf [DEPTH];
    logic [BW-1:0]     rd_data_q;

    logic              px_s;
    logic              frame_rise_s;
    logic              frame_fall_s;
    logic              line_fall_s;
    logic              row_odd_eff_s;
    logic              in_range_s;
    logic [AW-1:0]     pair_addr_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic [BW-1:0]     wr_data_s;
    logic [DATA_W-1:0] buf_g1_s;
    logic [4:0]        buf_r_s;
    logic [DATA_W:0]   gsum_s;
    logic [5:0]        g6_s;

    // Input qualification, edge detection and binning arithmetic
    always_comb begin
        px_s          = in_frame_valid & in_line_valid;
        frame_rise_s  = in_frame_valid & ~fval_q;
        frame_fall_s  = ~in_frame_valid & fval_q;
        line_fall_s   = ~in_line_valid & lval_q;
        // A pixel arriving with the FVAL rising edge already belongs to row 0
        row_odd_eff_s = row_odd_q & ~frame_rise_s;
        in_range_s    = (col_q < COL_MAX);
        pair_addr_s   = AW'(col_q >> 1);
        buf_g1_s      = rd_data_q[BW-1:5];
        buf_r_s       = rd_data_q[4:0];
        gsum_s        = {1'b0, buf_g1_s} + {1'b0, in_data};
        g6_s          = 6'(gsum_s >> (DATA_W - 5));
        wr_data_s     = {g1_q, in_data[DATA_W-1 -: 5]};
    end

    // Next-state logic: column/row tracking, pair assembly, output formation
    always_comb begin
        fval_d          = in_frame_valid;
        lval_d          = in_line_valid;
        col_d           = col_q;
        row_odd_d       = row_odd_q;
        first_pending_d = first_pending_q;
        overflow_d      = overflow_q;
        g1_d            = g1_q;
        b_d             = b_q;
        wr_en_s         = 1'b0;
        rd_en_s         = 1'b0;
        out_valid_d     = 1'b0;
        out_pixel_d     = out_pixel_q;
        out_sof_d       = 1'b0;
        out_last_col_d  = 1'b0;

        if (frame_rise_s) begin
            row_odd_d       = 1'b0;
            first_pending_d = 1'b1;
            overflow_d      = 1'b0;
        end else begin
            first_pending_d = first_pending_q;
        end

        if (frame_fall_s) begin
            // Abandon any partial pair; the frame produces nothing further
            col_d     = {CW{1'b0}};
            row_odd_d = 1'b0;
        end else if (line_fall_s) begin
            col_d     = {CW{1'b0}};
            // Lines that ended outside an active frame do not count as rows
            row_odd_d = (in_frame_valid && !frame_rise_s) ? ~row_odd_q : 1'b0;
        end else if (px_s && in_range_s) begin
            col_d = col_q + COL_ONE;
            if (!row_odd_eff_s) begin
                if (!col_q[0]) begin
                    g1_d = in_data;
                end else begin
                    wr_en_s = 1'b1;
                end
            end else begin
                if (!col_q[0]) begin
                    b_d     = in_data[DATA_W-1 -: 5];
                    rd_en_s = 1'b1;
                end else begin
                    out_valid_d     = 1'b1;
                    out_pixel_d     = {buf_r_s, g6_s, b_q};
                    out_sof_d       = first_pending_q;
                    first_pending_d = 1'b0;
                    out_last_col_d  = (col_q == COL_LAST);
                end
            end
        end else if (px_s) begin
            // Beyond the buffer width: drop the pixel, keep col saturated
            overflow_d = 1'b1;
        end else begin
            col_d = col_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fval_q          <= 1'b0;
            lval_q          <= 1'b0;
            col_q           <= {CW{1'b0}};
            row_odd_q       <= 1'b0;
            first_pending_q <= 1'b1;
            overflow_q      <= 1'b0;
            g1_q            <= {DATA_W{1'b0}};
            b_q             <= 5'd0;
            out_valid_q     <= 1'b0;
            out_pixel_q     <= 16'd0;
            out_sof_q       <= 1'b0;
            out_last_col_q  <= 1'b0;
        end else begin
            fval_q          <= fval_d;
            lval_q          <= lval_d;
            col_q           <= col_d;
            row_odd_q       <= row_odd_d;
            first_pending_q <= first_pending_d;
            overflow_q      <= overflow_d;
            g1_q            <= g1_d;
            b_q             <= b_d;
            out_valid_q     <= out_valid_d;
            out_pixel_q     <= out_pixel_d;
            out_sof_q       <= out_sof_d;
            out_last_col_q  <= out_last_col_d;
        end
    end

    // Line buffer: even rows write, odd rows read one cycle ahead of use
    always_ff @(posedge clk) begin
        if (wr_en_s && reset_n) begin
            line_buf[pair_addr_s] <= wr_data_s;
        end
        if (rd_en_s) begin
            rd_data_q <= line_buf[pair_addr_s];
        end
    end

`ifdef BAYER_FRAME_CNT_EN
    logic [31:0] pix_cnt_q, pix_cnt_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;

    // Per-frame output counter, snapshotted on the FVAL falling edge
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_fall_s) begin
            frame_cnt_d = pix_cnt_q + {31'd0, out_valid_q};
            pix_cnt_d   = 32'd0;
        end else if (out_valid_q) begin
            pix_cnt_d = pix_cnt_q + 32'd1;
        end else begin
            pix_cnt_d = pix_cnt_q;
        end
    end

    // Frame counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_cnt_q   <= 32'd0;
            frame_cnt_q <= 32'd0;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_pixel_count = frame_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_sof   = out_sof_q;
    // The pair closes its line if it hit the width limit or LVAL drops
    // immediately behind it; the latter is only visible this cycle.
    assign out_eol   = out_valid_q & (out_last_col_q | ~in_line_valid);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_camera_bayer_rgb565.sv
module tb_camera_bayer_rgb565;

    localparam int LW    = 16;
    localparam int DW    = 12;
    localparam int SCALE = 1 << (DW - 5);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          fval;
    logic          lval;
    logic [DW-1:0] din;
    logic          out_valid;
    logic [15:0]   out_pixel;
    logic          out_sof;
    logic          out_eol;
    logic          overflow;
`ifdef BAYER_FRAME_CNT_EN
    logic [31:0]   frame_pixel_count;
`endif

    camera_bayer_rgb565 #(.LINE_WIDTH(LW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_frame_valid (fval),
        .in_line_valid  (lval),
        .in_data        (din),
        .out_valid      (out_valid),
        .out_pixel      (out_pixel),
        .out_sof        (out_sof),
        .out_eol        (out_eol),
        .overflow       (overflow)
`ifdef BAYER_FRAME_CNT_EN
        ,
        .frame_pixel_count (frame_pixel_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int pix;
        bit sof;
        bit eol;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference state: buffered even-row pairs, pixels of the current line
    int   mg1 [LW/2];
    int   mr  [LW/2];
    int   lp  [64];
    bit   row_odd_m;
    bit   first_m;
    bit   ovf_m;
    int   frame_out_m;

    // Cycle counter used to check the fixed one-clock latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every DUT output must match the oldest expectation
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual pixel=%h expected no output (cycle %0d)", out_pixel, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pixel",   32'(out_pixel), 32'(mon_e.pix));
                check("sof",     32'(out_sof),   32'(mon_e.sof));
                check("eol",     32'(out_eol),   32'(mon_e.eol));
                check("latency", 32'(cyc),       32'(mon_e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) lp[i] = int'($urandom_range(0, (1 << DW) - 1));
    endtask

    // Drive n pixels of one line. Pairs beyond LW are dropped; an odd row
    // produces one output per complete pair, marked end-of-line if it is at
    // the width limit or (when 'ends') it is the last pixel before LVAL drops.
    task automatic drive_pixels(input int n, input bit odd, input bit ends);
        int   m;
        int   p;
        bit   has;
        exp_t e;
        m = (n < LW) ? n : LW;
        for (int i = 0; i < n; i++) begin
            has = 1'b0;
            if (i < m && (i % 2) == 1) begin
                p = i / 2;
                if (!odd) begin
                    mg1[p] = lp[i-1];
                    mr[p]  = lp[i];
                end else begin
                    e.pix = (mr[p] / SCALE) * 2048 + ((mg1[p] + lp[i]) / SCALE) * 32 + (lp[i-1] / SCALE);
                    e.sof = first_m;
                    e.eol = (i == LW - 1) || (ends && n == i + 1);
                    first_m = 1'b0;
                    has = 1'b1;
                end
            end
            if (i >= LW) ovf_m = 1'b1;
            lval = 1'b1;
            din  = DW'(lp[i]);
            if (has) begin
                e.cyc = cyc + 1;
                exp_q.push_back(e);
                frame_out_m++;
            end
            tick();
        end
    endtask

    task automatic end_line();
        lval = 1'b0;
        din  = DW'($urandom);
        tick();
        row_odd_m = ~row_odd_m;
        repeat (3) tick();
    endtask

    task automatic start_frame();
        fval        = 1'b1;
        row_odd_m   = 1'b0;
        first_m     = 1'b1;
        ovf_m       = 1'b0;
        frame_out_m = 0;
        tick();
        check("overflow_cleared_on_fval_rise", 32'(overflow), 32'd0);
        tick();
    endtask

    task automatic end_frame();
        fval = 1'b0;
        lval = 1'b0;
        repeat (3) tick();
        check("overflow_at_frame_end", 32'(overflow), 32'(ovf_m));
`ifdef BAYER_FRAME_CNT_EN
        check("frame_pixel_count", frame_pixel_count, 32'(frame_out_m));
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_pixel"}, 32'(out_pixel), 32'd0);
        check({tag, "_out_sof"},   32'(out_sof),   32'd0);
        check({tag, "_out_eol"},   32'(out_eol),   32'd0);
        check({tag, "_overflow"},  32'(overflow),  32'd0);
    endtask

    initial begin
        int nl;
        int n;
        reset_n = 1'b0;
        fval    = 1'b0;
        lval    = 1'b0;
        din     = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
`ifdef BAYER_FRAME_CNT_EN
        check("reset_frame_count", frame_pixel_count, 32'd0);
`endif
        reset_n = 1'b1;
        tick();

        // Full-width frame so every buffer entry holds known data
        start_frame();
        for (int r = 0; r < 2; r++) begin
            fill_rand(LW);
            drive_pixels(LW, row_odd_m, 1'b1);
            end_line();
        end
        end_frame();

        // Uniform pattern, 4 lines x 8 pixels: G=0x800, R=0xFFF, B=0
        start_frame();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin
                if ((r % 2) == 0) lp[i] = ((i % 2) == 0) ? 'h800 : 'hFFF;
                else              lp[i] = ((i % 2) == 0) ? 'h000 : 'h800;
            end
            drive_pixels(8, row_odd_m, 1'b1);
            end_line();
        end
        end_frame();

        // Single 2x2 block
        start_frame();
        lp[0] = 'h123; lp[1] = 'hABC;
        drive_pixels(2, row_odd_m, 1'b1);
        end_line();
        lp[0] = 'h456; lp[1] = 'h321;
        drive_pixels(2, row_odd_m, 1'b1);
        end_line();
        end_frame();

        // Over-length lines: pixels past LW are dropped, overflow is sticky
        start_frame();
        for (int r = 0; r < 2; r++) begin
            fill_rand(LW + 4);
            drive_pixels(LW + 4, row_odd_m, 1'b1);
            end_line();
        end
        end_frame();

        // FVAL drops after 3 pixels of the odd row; partial pair discarded
        start_frame();
        fill_rand(8);
        drive_pixels(8, row_odd_m, 1'b1);
        end_line();
        fill_rand(3);
        drive_pixels(3, row_odd_m, 1'b0);
        fval = 1'b0;
        tick();
        lval = 1'b0;
        repeat (3) tick();
`ifdef BAYER_FRAME_CNT_EN
        check("frame_pixel_count_drop", frame_pixel_count, 32'(frame_out_m));
`endif
        // LVAL activity outside a frame is ignored
        for (int i = 0; i < 6; i++) begin
            lval = 1'b1;
            din  = DW'($urandom);
            tick();
        end
        lval = 1'b0;
        repeat (2) tick();
        // Next frame starts on an even row and flags its first output
        start_frame();
        for (int r = 0; r < 2; r++) begin
            fill_rand(6);
            drive_pixels(6, row_odd_m, 1'b1);
            end_line();
        end
        end_frame();

        // Reset pulse in the middle of an odd line
        start_frame();
        fill_rand(8);
        drive_pixels(8, row_odd_m, 1'b1);
        end_line();
        fill_rand(8);
        drive_pixels(4, row_odd_m, 1'b0);
        reset_n = 1'b0;
        lval    = 1'b1;
        din     = DW'(lp[4]);
        tick();
        reset_n = 1'b1;
        check_idle_outputs("midline_reset");
`ifdef BAYER_FRAME_CNT_EN
        check("midline_reset_frame_count", frame_pixel_count, 32'd0);
`endif
        row_odd_m   = 1'b0;
        first_m     = 1'b1;
        ovf_m       = 1'b0;
        frame_out_m = 0;
        for (int i = 0; i < 3; i++) lp[i] = lp[i + 5];
        drive_pixels(3, row_odd_m, 1'b1);
        end_line();
        fill_rand(8);
        drive_pixels(8, row_odd_m, 1'b1);
        end_line();
        end_frame();

        // Randomized frames, including odd, short and over-length lines
        for (int f = 0; f < 8; f++) begin
            start_frame();
            nl = int'($urandom_range(2, 5));
            for (int r = 0; r < nl; r++) begin
                n = int'($urandom_range(2, LW + 4));
                fill_rand(n);
                drive_pixels(n, row_odd_m, 1'b1);
                end_line();
            end
            end_frame();
        end

        repeat (5) tick();
        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
